// File: rtl/keypad_pkg.sv
// Shared types and key-code lookup for the 4x3 keypad scanner.
// Key map: rows 1-2-3 / 4-5-6 / 7-8-9 / *-0-#.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    RELEASE
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'b1011;
  localparam logic [3:0] KEY_HASH = 4'b1100;

  localparam logic [3:0] KEY_LUT [0:3][0:2] = '{
    '{4'd1, 4'd2, 4'd3},
    '{4'd4, 4'd5, 4'd6},
    '{4'd7, 4'd8, 4'd9},
    '{KEY_STAR, 4'd0, KEY_HASH}
  };

  function automatic logic [1:0] row_idx(input logic [3:0] row);
    row_idx = 2'd0;
    unique case (1'b1)
      ~row[0]: row_idx = 2'd0;
      ~row[1]: row_idx = 2'd1;
      ~row[2]: row_idx = 2'd2;
      ~row[3]: row_idx = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] col_idx(input logic [2:0] col);
    col_idx = 2'd0;
    unique case (1'b1)
      ~col[0]: col_idx = 2'd0;
      ~col[1]: col_idx = 2'd1;
      ~col[2]: col_idx = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] key_code(
    input logic [1:0] r,
    input logic [1:0] c
  );
    key_code = 4'd0;
    if (c != 2'd3)
      key_code = KEY_LUT[r][c];
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Saturating match counter shared by press and release qualification.
// done fires on the LIMIT-th consecutive matching cycle.
module keypad_debounce #(
  parameter int LIMIT = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic match,
  output logic done
);

  localparam int W = $clog2(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (!RST || clr || !match)
      cnt <= '0;
    else if (cnt != LAST)
      cnt <= cnt + 1'b1;
  end

  assign done = match && !clr && (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with debounce, one-shot key strobe and hold flag.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000,
  parameter int REPEAT_CNT   = 25000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] ROW,
  output logic [2:0] COL,
  output logic [3:0] BCD_OUT,
  output logic       KEY_VALID,
  output logic       KEY_HELD
);

  import keypad_pkg::*;

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  state_t state, state_d;
  logic [DW-1:0] div_q;
  logic [3:0] cap_row;
  logic [3:0] cap_code;
  logic sample, hit;
  logic db_clr, db_match, db_done;
  logic rep_fire;

  assign sample = (state == SCAN) && (div_q == DIV_LAST);
  assign hit    = sample && $onehot(~ROW);

  assign db_clr   = !((state == DEBOUNCE) || (state == RELEASE));
  assign db_match = (state == DEBOUNCE) ? (ROW == cap_row)
                                        : (ROW == 4'hF);

  keypad_debounce #(
    .LIMIT(DEBOUNCE_CNT)
  ) u_db (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (db_clr),
    .match(db_match),
    .done (db_done)
  );

  always_ff @(posedge CLK) begin
    if (!RST)
      state <= SCAN;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      SCAN:
        if (hit) state_d = DEBOUNCE;
      DEBOUNCE:
        if (ROW != cap_row) state_d = SCAN;
        else if (db_done)   state_d = EMIT;
      EMIT:
        state_d = RELEASE;
      RELEASE:
        if (db_done) state_d = SCAN;
      default:
        state_d = SCAN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      COL       <= 3'b110;
      div_q     <= '0;
      cap_row   <= 4'hF;
      cap_code  <= 4'd0;
      BCD_OUT   <= 4'd0;
      KEY_VALID <= 1'b0;
      KEY_HELD  <= 1'b0;
    end else begin
      KEY_VALID <= (state_d == EMIT) || rep_fire;
      if (state == SCAN) begin
        if (sample) begin
          div_q <= '0;
          if (hit) begin
            cap_row  <= ROW;
            cap_code <= key_code(row_idx(ROW), col_idx(COL));
          end else begin
            COL <= {COL[1:0], COL[2]};
          end
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
      if (state_d == EMIT) begin
        BCD_OUT  <= cap_code;
        KEY_HELD <= 1'b1;
      end
      if ((state == RELEASE) && db_done) begin
        KEY_HELD <= 1'b0;
        COL      <= 3'b110;
        div_q    <= '0;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CNT - 1);

  logic [RW-1:0] rep_q;
  logic held;

  assign held     = (ROW != 4'hF);
  assign rep_fire = (state == RELEASE) && held && (rep_q == REP_LAST);

  // Counting starts in EMIT so repeats land exactly REPEAT_CNT apart.
  always_ff @(posedge CLK) begin
    if (!RST || rep_fire ||
        !((state == EMIT) || (state == RELEASE)) ||
        ((state == RELEASE) && !held))
      rep_q <= '0;
    else if (rep_q != REP_LAST)
      rep_q <= rep_q + 1'b1;
  end
`else
  assign rep_fire = (REPEAT_CNT < 0);
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized self-checking bench for keypad_scanner with a behavioural keypad.
// Expected codes come from the key map; timing from scan/debounce windows.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int RP = 32;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic [3:0] ROW;
  logic [2:0] COL;
  logic [3:0] BCD_OUT;
  logic KEY_VALID;
  logic KEY_HELD;

  logic [11:0] keys = '0;
  int n_chk = 0;
  int n_err = 0;
  int stb = 0;
  int cyc = 0;
  logic kv_prev = 1'b0;
  logic [3:0] stb_code = 4'd0;
  int stb_cyc[$];

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_CNT(DB),
    .REPEAT_CNT(RP)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .ROW(ROW),
    .COL(COL),
    .BCD_OUT(BCD_OUT),
    .KEY_VALID(KEY_VALID),
    .KEY_HELD(KEY_HELD)
  );

  always #5 CLK = ~CLK;

  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (keys[r*3+c] && !COL[c])
          ROW[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (KEY_VALID) begin
      chk("kv_pair", {31'd0, kv_prev}, 32'd0);
      stb++;
      stb_code = BCD_OUT;
      stb_cyc.push_back(cyc);
    end
    kv_prev = KEY_VALID;
  end

  function automatic logic [3:0] exp_code(input int k);
    int r, c;
    r = k / 3;
    c = k % 3;
    if (r < 3) return 4'(r*3 + c + 1);
    if (c == 0) return 4'd11;
    if (c == 1) return 4'd0;
    return 4'd12;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_col"}, {29'd0, COL}, 32'd6);
    chk({tag, "_bcd"}, {28'd0, BCD_OUT}, 32'd0);
    chk({tag, "_kv"}, {31'd0, KEY_VALID}, 32'd0);
    chk({tag, "_kh"}, {31'd0, KEY_HELD}, 32'd0);
  endtask

  task automatic press_accept(input int k);
    int s;
    s = stb;
    keys[k] = 1'b1;
    tick(DB);
    chk("early", stb - s, 0);
    for (int i = 0; i < 40 && stb == s; i++)
      tick(1);
    chk("strobe", stb - s, 1);
    chk("code", {28'd0, stb_code}, {28'd0, exp_code(k)});
    chk("bcd", {28'd0, BCD_OUT}, {28'd0, exp_code(k)});
    chk("held", {31'd0, KEY_HELD}, 32'd1);
  endtask

  task automatic release_all(input int k);
    keys = '0;
    tick(DB - 1);
    chk("held_hold", {31'd0, KEY_HELD}, 32'd1);
    tick(1);
    chk("held_clr", {31'd0, KEY_HELD}, 32'd0);
    chk("col_restart", {29'd0, COL}, 32'd6);
    chk("bcd_keep", {28'd0, BCD_OUT}, {28'd0, exp_code(k)});
  endtask

  initial begin
    int k, k2, s, base;
    logic [2:0] ce;

    tick(3);
    chk_reset("rst");
    RST = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      ce = 3'b001 << (((i + 1) / SD) % 3);
      ce = ~ce;
      chk("scan_col", {29'd0, COL}, {29'd0, ce});
    end
    chk("idle_kv", stb, 0);

    press_accept(4);
    release_all(4);
    press_accept(9);
    release_all(9);
    press_accept(11);
    release_all(11);

    repeat (6) begin
      k = $urandom_range(0, 11);
      press_accept(k);
      tick($urandom_range(0, 10));
      release_all(k);
    end

    k = $urandom_range(0, 11);
    s = stb;
    repeat (3) begin
      keys[k] = 1'b1;
      tick(5);
      keys[k] = 1'b0;
      tick(1);
    end
    chk("bounce_none", stb - s, 0);
    press_accept(k);
    release_all(k);
    chk("bounce_one", stb - s, 1);

    k = $urandom_range(0, 11);
    press_accept(k);
    s = stb;
    k2 = (k + 1 + $urandom_range(0, 10)) % 12;
    keys[k2] = 1'b1;
    tick(15);
    chk("second_ign", stb - s, 0);
    release_all(k);
    chk("second_rel", stb - s, 0);

    k = $urandom_range(0, 11);
    s = stb;
    keys[k] = 1'b1;
    tick($urandom_range(1, 8));
    RST = 1'b0;
    tick(1);
    chk_reset("rst_deb");
    keys = '0;
    tick(2);
    RST = 1'b1;
    tick(20);
    chk("rst_deb_nostb", stb - s, 0);

    k = $urandom_range(0, 11);
    press_accept(k);
    s = stb;
    tick(3);
    RST = 1'b0;
    tick(1);
    chk_reset("rst_rel");
    keys = '0;
    tick(1);
    RST = 1'b1;
    tick(20);
    chk("rst_rel_nostb", stb - s, 0);

    s = stb;
    base = stb_cyc.size();
    press_accept(6);
    tick(100);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("rep_n", stb - s, 4);
    if (stb_cyc.size() >= base + 4)
      for (int i = 1; i < 4; i++)
        chk("rep_gap", stb_cyc[base+i] - stb_cyc[base+i-1], RP);
    chk("rep_code", {28'd0, stb_code}, 32'd7);
`else
    chk("rep_n", stb - s, 1);
`endif
    chk("rep_bcd", {28'd0, BCD_OUT}, 32'd7);
    release_all(6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
